pipeline_ctrl: RTL and testbench

- Central sequencer for the 5-stage MIPS pipeline.
- Generates the global advance enable (o_step) consumed by IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC write enable.
- Owns run/debug-step/halt sequencing, load-use stall detection and branch/jump flush generation.
- Flushes are gated here, because the pipeline registers apply flush regardless of step.

---
 rtl/pipeline_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: run/debug-step/halt control,
// load-use stall detection and branch/jump flush gating, plus cycle/stall counters.
module pipeline_ctrl #(
  parameter int RNBITS  = 5,
  parameter int CNTBITS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic               i_step_req,
  input  logic               i_clear,
  input  logic               i_IDEX_MemRead,
  input  logic [RNBITS-1:0]  i_IDEX_Rt,
  input  logic [RNBITS-1:0]  i_IFID_Rs,
  input  logic [RNBITS-1:0]  i_IFID_Rt,
  input  logic               i_branch_taken,
  input  logic               i_jump_id,
  input  logic               i_halt_wb,
  output logic               o_step,
  output logic               o_pc_write,
  output logic               o_IFID_write,
  output logic               o_IFID_flush,
  output logic               o_IDEX_flush,
  output logic               o_halted,
  output logic [1:0]         o_state,
  output logic [CNTBITS-1:0] o_cycle_count,
  output logic [CNTBITS-1:0] o_stall_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEPWAIT,
    S_STEP,
    S_HALTED
  } state_t;

  state_t state, state_next;
  logic   step_req_q;
  logic   step_edge;
  logic   hazard;
  logic   stall;

  assign step_edge = i_step_req & ~step_req_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= S_IDLE;
      step_req_q <= 1'b0;
    end else begin
      state      <= state_next;
      step_req_q <= i_step_req;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (i_start) state_next = i_mode ? S_STEPWAIT : S_RUN;
      S_RUN:      if (i_halt_wb) state_next = S_HALTED;
      S_STEPWAIT: if (step_edge) state_next = S_STEP;
      S_STEP:     state_next = i_halt_wb ? S_HALTED : S_STEPWAIT;
      S_HALTED:   if (i_clear) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  assign hazard = i_IDEX_MemRead && (i_IDEX_Rt != '0) &&
                  ((i_IDEX_Rt == i_IFID_Rs) || (i_IDEX_Rt == i_IFID_Rt));

  // Branch flush outranks a stall, a stall outranks a jump; nothing fires without o_step.
  always_comb begin
    o_step       = (state == S_RUN) || (state == S_STEP);
    o_halted     = (state == S_HALTED);
    o_pc_write   = 1'b0;
    o_IFID_write = 1'b0;
    o_IFID_flush = 1'b0;
    o_IDEX_flush = 1'b0;
    stall        = 1'b0;
    case (state)
      S_RUN:      o_state = 2'b01;
      S_STEPWAIT: o_state = 2'b10;
      S_STEP:     o_state = 2'b11;
      default:    o_state = 2'b00;
    endcase
    if (o_step) begin
      if (i_branch_taken) begin
        o_IFID_flush = 1'b1;
        o_IDEX_flush = 1'b1;
        o_pc_write   = 1'b1;
        o_IFID_write = 1'b1;
      end else if (hazard) begin
        stall        = 1'b1;
        o_IDEX_flush = 1'b1;
      end else if (i_jump_id) begin
        o_IFID_flush = 1'b1;
        o_pc_write   = 1'b1;
        o_IFID_write = 1'b1;
      end else begin
        o_pc_write   = 1'b1;
        o_IFID_write = 1'b1;
      end
    end
  end

  // Counters restart whenever a new run or debug session is launched from IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_cycle_count <= '0;
      o_stall_count <= '0;
    end else if (state == S_IDLE && i_start) begin
      o_cycle_count <= '0;
      o_stall_count <= '0;
    end else begin
      if (o_step) o_cycle_count <= o_cycle_count + CNTBITS'(1);
      if (stall)  o_stall_count <= o_stall_count + CNTBITS'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the sequencer rules.
module tb_pipeline_ctrl;

  localparam int RNBITS  = 5;
  localparam int CNTBITS = 8;

  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_STEP = 3, M_HALT = 4;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b0;
  logic               i_start = 1'b0, i_mode = 1'b0, i_step_req = 1'b0, i_clear = 1'b0;
  logic               i_IDEX_MemRead = 1'b0;
  logic [RNBITS-1:0]  i_IDEX_Rt = '0, i_IFID_Rs = '0, i_IFID_Rt = '0;
  logic               i_branch_taken = 1'b0, i_jump_id = 1'b0, i_halt_wb = 1'b0;
  logic               o_step, o_pc_write, o_IFID_write, o_IFID_flush, o_IDEX_flush, o_halted;
  logic [1:0]         o_state;
  logic [CNTBITS-1:0] o_cycle_count, o_stall_count;

  int checks = 0;
  int errors = 0;

  int                 ms = M_IDLE;
  logic [CNTBITS-1:0] m_cyc = '0, m_stl = '0;
  logic               m_prev = 1'b0;
  logic               e_step, e_pc, e_ifw, e_iff, e_idf, e_halt, e_stall;
  logic [1:0]         e_state;
  logic [7:0]         expv, obs;
  logic [3:0]         ctl;

  assign obs = {o_step, o_pc_write, o_IFID_write, o_IFID_flush, o_IDEX_flush, o_halted, o_state};
  assign ctl = {o_pc_write, o_IFID_write, o_IFID_flush, o_IDEX_flush};

  pipeline_ctrl #(.RNBITS(RNBITS), .CNTBITS(CNTBITS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_mode(i_mode),
    .i_step_req(i_step_req), .i_clear(i_clear), .i_IDEX_MemRead(i_IDEX_MemRead),
    .i_IDEX_Rt(i_IDEX_Rt), .i_IFID_Rs(i_IFID_Rs), .i_IFID_Rt(i_IFID_Rt),
    .i_branch_taken(i_branch_taken), .i_jump_id(i_jump_id), .i_halt_wb(i_halt_wb),
    .o_step(o_step), .o_pc_write(o_pc_write), .o_IFID_write(o_IFID_write),
    .o_IFID_flush(o_IFID_flush), .o_IDEX_flush(o_IDEX_flush), .o_halted(o_halted),
    .o_state(o_state), .o_cycle_count(o_cycle_count), .o_stall_count(o_stall_count)
  );

  always #5 i_clk = ~i_clk;

  // Expected combinational outputs for the current model state and inputs.
  task automatic model_comb();
    logic hz;
    hz = i_IDEX_MemRead && (i_IDEX_Rt != 0) && (i_IDEX_Rt == i_IFID_Rs || i_IDEX_Rt == i_IFID_Rt);
    e_step = (ms == M_RUN) || (ms == M_STEP);
    e_halt = (ms == M_HALT);
    e_state = (ms == M_RUN) ? 2'b01 : (ms == M_WAIT) ? 2'b10 : (ms == M_STEP) ? 2'b11 : 2'b00;
    {e_pc, e_ifw, e_iff, e_idf, e_stall} = 5'b0;
    if (e_step) begin
      if (i_branch_taken)  {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
      else if (hz)         begin {e_pc, e_ifw, e_iff, e_idf} = 4'b0001; e_stall = 1'b1; end
      else if (i_jump_id)  {e_pc, e_ifw, e_iff, e_idf} = 4'b1110;
      else                 {e_pc, e_ifw, e_iff, e_idf} = 4'b1100;
    end
    expv = {e_step, e_pc, e_ifw, e_iff, e_idf, e_halt, e_state};
  endtask

  task automatic tick();
    model_comb();
    if (!i_reset) begin
      ms = M_IDLE; m_cyc = '0; m_stl = '0; m_prev = 1'b0;
    end else begin
      if (e_step)  m_cyc = m_cyc + 1'b1;
      if (e_stall) m_stl = m_stl + 1'b1;
      case (ms)
        M_IDLE: if (i_start) begin ms = i_mode ? M_WAIT : M_RUN; m_cyc = '0; m_stl = '0; end
        M_RUN:  if (i_halt_wb) ms = M_HALT;
        M_WAIT: if (i_step_req && !m_prev) ms = M_STEP;
        M_STEP: ms = i_halt_wb ? M_HALT : M_WAIT;
        default: if (i_clear) ms = M_IDLE;
      endcase
      m_prev = i_step_req;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic quiet_inputs();
    i_start = 0; i_mode = 0; i_step_req = 0; i_clear = 0; i_halt_wb = 0;
    i_IDEX_MemRead = 0; i_IDEX_Rt = 0; i_IFID_Rs = 0; i_IFID_Rt = 0;
    i_branch_taken = 0; i_jump_id = 0;
  endtask

  task automatic do_reset();
    i_reset = 0; quiet_inputs(); tick(); i_reset = 1; #1;
  endtask

  task automatic test_reset();
    do_reset(); tick(); model_comb();
    checks++; if (obs !== 8'h00) begin errors++; $display("[TB] FAIL reset_outputs got %b want %b", obs, 8'h00); end
    checks++; if (obs !== expv) begin errors++; $display("[TB] FAIL reset_model got %b want %b", obs, expv); end
    checks++; if ({o_cycle_count, o_stall_count} !== '0) begin errors++;
      $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", o_cycle_count, o_stall_count); end
  endtask

  task automatic test_run_halt();
    do_reset();
    i_start = 1; i_mode = 0; #1; model_comb();
    checks++; if (obs !== expv) begin errors++; $display("[TB] FAIL idle_before_start got %b want %b", obs, expv); end
    tick(); i_start = 0; #1;
    checks++; if (o_state !== 2'b01 || o_step !== 1'b1) begin errors++;
      $display("[TB] FAIL run_entry got state %b step %b want 01/1", o_state, o_step); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (o_step !== 1'b1) begin errors++; $display("[TB] FAIL run_step cycle %0d got %b want 1", i, o_step); end
      tick();
    end
    i_halt_wb = 1; #1;
    checks++; if (o_step !== 1'b1) begin errors++; $display("[TB] FAIL halt_cycle_step got %b want 1", o_step); end
    tick(); i_halt_wb = 0; #1; model_comb();
    checks++; if (o_halted !== 1'b1 || o_step !== 1'b0 || o_state !== 2'b00) begin errors++;
      $display("[TB] FAIL halted_state got halted %b step %b state %b want 1/0/00", o_halted, o_step, o_state); end
    checks++; if (o_cycle_count !== 11) begin errors++; $display("[TB] FAIL halt_cycle_count got %0d want 11", o_cycle_count); end
    i_start = 1; tick(); i_start = 0; #1;
    checks++; if (o_halted !== 1'b1 || o_step !== 1'b0) begin errors++;
      $display("[TB] FAIL start_ignored_halted got halted %b step %b want 1/0", o_halted, o_step); end
    i_clear = 1; tick(); i_clear = 0; #1; model_comb();
    checks++; if (obs !== 8'h00 || obs !== expv) begin errors++; $display("[TB] FAIL clear_to_idle got %b want %b", obs, expv); end
  endtask

  task automatic test_step_mode();
    int pulses;
    do_reset();
    i_start = 1; i_mode = 1; tick(); i_start = 0; i_mode = 0; #1;
    checks++; if (o_state !== 2'b10 || o_step !== 1'b0) begin errors++;
      $display("[TB] FAIL stepwait_entry got state %b step %b want 10/0", o_state, o_step); end
    pulses = 0;
    i_step_req = 1;
    for (int c = 0; c < 5; c++) begin
      #1; model_comb();
      checks++; if (obs !== expv) begin errors++; $display("[TB] FAIL step_hold cycle %0d got %b want %b", c, obs, expv); end
      if (o_step) pulses++;
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL step_hold_pulses got %0d want 1", pulses); end
    for (int k = 0; k < 3; k++) begin
      i_step_req = 0;
      repeat (2) begin if (o_step) pulses++; tick(); end
      i_step_req = 1;
      repeat (3) begin if (o_step) pulses++; tick(); end
    end
    i_step_req = 0;
    repeat (2) begin if (o_step) pulses++; tick(); end
    checks++; if (pulses != 4) begin errors++; $display("[TB] FAIL step_total_pulses got %0d want 4", pulses); end
    checks++; if (o_cycle_count !== 4 || o_cycle_count !== m_cyc) begin errors++;
      $display("[TB] FAIL step_cycle_count got %0d want 4", o_cycle_count); end
  endtask

  task automatic test_load_use();
    do_reset();
    i_start = 1; tick(); i_start = 0;
    i_IDEX_MemRead = 1; i_IDEX_Rt = 8; i_IFID_Rt = 8; i_IFID_Rs = 3; #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("[TB] FAIL load_use_ctl got %b want 0001", ctl); end
    tick();
    checks++; if (o_stall_count !== 1) begin errors++; $display("[TB] FAIL load_use_count got %0d want 1", o_stall_count); end
    i_jump_id = 1; i_IFID_Rt = 0; i_IDEX_Rt = 5; i_IFID_Rs = 5; #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("[TB] FAIL stall_over_jump got %b want 0001", ctl); end
    tick();
    i_IDEX_Rt = 0; i_IFID_Rs = 0; i_IFID_Rt = 0; #1;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("[TB] FAIL rt_zero_jump got %b want 1110", ctl); end
    i_jump_id = 0; #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("[TB] FAIL rt_zero_plain got %b want 1100", ctl); end
    tick();
    checks++; if (o_stall_count !== 2 || o_stall_count !== m_stl) begin errors++;
      $display("[TB] FAIL stall_count_after got %0d want 2", o_stall_count); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    i_start = 1; tick(); i_start = 0;
    i_IDEX_MemRead = 1; i_IDEX_Rt = 8; i_IFID_Rt = 8; i_branch_taken = 1; i_jump_id = 1; #1;
    checks++; if (ctl !== 4'b1111) begin errors++; $display("[TB] FAIL branch_over_stall got %b want 1111", ctl); end
    tick();
    checks++; if (o_stall_count !== 0) begin errors++; $display("[TB] FAIL branch_stall_uncounted got %0d want 0", o_stall_count); end
  endtask

  task automatic test_stepwait_gating();
    do_reset();
    i_start = 1; i_mode = 1; tick(); i_start = 0; i_mode = 0;
    i_IDEX_MemRead = 1; i_IDEX_Rt = 8; i_IFID_Rs = 8; i_branch_taken = 1; i_jump_id = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({o_step, ctl} !== 5'b0) begin errors++; $display("[TB] FAIL stepwait_gated cycle %0d got %b want 00000", c, {o_step, ctl}); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_start = 1; tick(); i_start = 0;
    repeat (5) tick();
    i_reset = 0; i_halt_wb = 1; i_start = 1; tick();
    i_reset = 1; i_halt_wb = 0; i_start = 0; #1;
    checks++; if (obs !== 8'h00 || {o_cycle_count, o_stall_count} !== '0) begin errors++;
      $display("[TB] FAIL reset_mid got %b cnt %0d/%0d want 0 0/0", obs, o_cycle_count, o_stall_count); end
    i_start = 1; tick(); i_start = 0; i_halt_wb = 1; tick(); i_halt_wb = 0; #1;
    checks++; if (o_halted !== 1'b1) begin errors++; $display("[TB] FAIL reach_halted got %b want 1", o_halted); end
    i_clear = 1; tick(); i_clear = 0; #1;
    checks++; if (o_halted !== 1'b0 || o_state !== 2'b00 || o_step !== 1'b0) begin errors++;
      $display("[TB] FAIL clear_idle got halted %b state %b step %b want 0/00/0", o_halted, o_state, o_step); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      i_reset        = ($urandom_range(0, 149) != 0);
      i_start        = ($urandom_range(0, 5) == 0);
      i_mode         = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) i_step_req = ~i_step_req;
      i_clear        = ($urandom_range(0, 7) == 0);
      i_halt_wb      = ($urandom_range(0, 24) == 0);
      i_IDEX_MemRead = 1'($urandom_range(0, 1));
      i_IDEX_Rt      = RNBITS'($urandom_range(0, 3));
      i_IFID_Rs      = RNBITS'($urandom_range(0, 3));
      i_IFID_Rt      = RNBITS'($urandom_range(0, 3));
      i_branch_taken = ($urandom_range(0, 3) == 0);
      i_jump_id      = ($urandom_range(0, 3) == 0);
      #1; model_comb();
      checks++; if (obs !== expv) begin errors++; $display("[TB] FAIL rand_outputs cycle %0d got %b want %b", c, obs, expv); end
      checks++; if (o_cycle_count !== m_cyc || o_stall_count !== m_stl) begin errors++;
        $display("[TB] FAIL rand_counters cycle %0d got %0d/%0d want %0d/%0d", c, o_cycle_count, o_stall_count, m_cyc, m_stl); end
      tick();
    end
    i_reset = 1;
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_step_mode();
    test_load_use();
    test_branch_priority();
    test_stepwait_gating();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
